// File: rtl/cache_control_l2_assoc_if.sv
// Bus between the L2 set-associative cache controller and its CPU port,
// tag/data arrays and physical memory.
interface cache_control_l2_assoc_if #(
  parameter int WAYS  = 4,
  parameter int BEATS = 4,
  parameter int CNT_W = 16
);
  localparam int WAY_W  = (WAYS  > 1) ? $clog2(WAYS)  : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic              mem_read;
  logic              mem_write;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAYS-1:0]   valid_vec;
  logic [WAYS-1:0]   dirty_vec;
  logic [WAY_W-1:0]  lru_way;
  logic              pmem_resp;

  logic              real_mem_resp;
  logic [WAY_W-1:0]  sel_way;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_mux_sel;
  logic [BEAT_W-1:0] beat_idx;
  logic              line_load;
  logic              tag_load;
  logic              dirty_set;
  logic              lru_update;
  logic [CNT_W-1:0]  miss_count;

  // The controller sits on the slave side; CPU, arrays and memory form the master.
  modport slave (
    input  mem_read, mem_write, hit, hit_way, valid_vec, dirty_vec, lru_way, pmem_resp,
    output real_mem_resp, sel_way, pmem_read, pmem_write, pmem_mux_sel, beat_idx,
           line_load, tag_load, dirty_set, lru_update, miss_count
  );

  modport master (
    output mem_read, mem_write, hit, hit_way, valid_vec, dirty_vec, lru_way, pmem_resp,
    input  real_mem_resp, sel_way, pmem_read, pmem_write, pmem_mux_sel, beat_idx,
           line_load, tag_load, dirty_set, lru_update, miss_count
  );
endinterface

// File: rtl/cache_control_l2_assoc.sv
// Control FSM for an N-way L2 cache: hit service, victim selection,
// dirty write-back burst, line fill burst and a saturating miss counter.
module cache_control_l2_assoc #(
  parameter int WAYS  = 4,
  parameter int BEATS = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  cache_control_l2_assoc_if.slave bus
);
  localparam int WAY_W  = (WAYS  > 1) ? $clog2(WAYS)  : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {CHECK, WRITE_BACK, ALLOCATE, UPDATE} state_t;

  state_t            state, state_next;
  logic [BEAT_W-1:0] beat_cnt, beat_next;
  logic [WAY_W-1:0]  victim, victim_next, victim_pick;
  logic [CNT_W-1:0]  miss_cnt, miss_next;

  logic              req;
  logic              victim_wb;
  logic              last_beat;

  logic              resp_c;
  logic [WAY_W-1:0]  sel_c;
  logic              pread_c;
  logic              pwrite_c;
  logic              mux_c;
  logic              line_load_c;
  logic              tag_load_c;
  logic              dirty_set_c;
  logic              lru_update_c;

  assign req       = bus.mem_read | bus.mem_write;
  assign last_beat = bus.pmem_resp && (beat_cnt == LAST_BEAT);

  // Lowest-index invalid way wins; only a full set falls back to LRU.
  always_comb begin
    victim_pick = bus.lru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!bus.valid_vec[i]) victim_pick = WAY_W'(i);
    end
  end

  assign victim_wb = bus.valid_vec[victim_pick] & bus.dirty_vec[victim_pick];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CHECK;
      beat_cnt <= '0;
      victim   <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_next;
      victim   <= victim_next;
      miss_cnt <= miss_next;
    end
  end

  always_comb begin
    state_next   = state;
    beat_next    = beat_cnt;
    victim_next  = victim;
    miss_next    = miss_cnt;
    resp_c       = 1'b0;
    sel_c        = '0;
    pread_c      = 1'b0;
    pwrite_c     = 1'b0;
    mux_c        = 1'b0;
    line_load_c  = 1'b0;
    tag_load_c   = 1'b0;
    dirty_set_c  = 1'b0;
    lru_update_c = 1'b0;

    case (state)
      CHECK: begin
        if (req) begin
          if (bus.hit) begin
            resp_c       = 1'b1;
            sel_c        = bus.hit_way;
            lru_update_c = 1'b1;
            dirty_set_c  = bus.mem_write;
          end else begin
            victim_next = victim_pick;
            beat_next   = '0;
            if (miss_cnt != CNT_MAX) miss_next = miss_cnt + 1'b1;
            state_next  = victim_wb ? WRITE_BACK : ALLOCATE;
          end
        end
      end

      // A started burst always runs to its last beat, whatever req does.
      WRITE_BACK: begin
        pwrite_c = 1'b1;
        mux_c    = 1'b1;
        sel_c    = victim;
        if (bus.pmem_resp) begin
          if (last_beat) begin
            beat_next  = '0;
            state_next = req ? ALLOCATE : CHECK;
          end else begin
            beat_next = beat_cnt + 1'b1;
          end
        end
      end

      ALLOCATE: begin
        pread_c     = 1'b1;
        sel_c       = victim;
        line_load_c = bus.pmem_resp;
        if (bus.pmem_resp) begin
          if (last_beat) begin
            beat_next  = '0;
            state_next = UPDATE;
          end else begin
            beat_next = beat_cnt + 1'b1;
          end
        end
      end

      UPDATE: begin
        tag_load_c = 1'b1;
        sel_c      = victim;
        state_next = CHECK;
      end

      default: state_next = CHECK;
    endcase
  end

  // Combinational hit outputs must also read 0 while reset is held low.
  assign bus.real_mem_resp = reset & resp_c;
  assign bus.sel_way       = reset ? sel_c : '0;
  assign bus.pmem_read     = reset & pread_c;
  assign bus.pmem_write    = reset & pwrite_c;
  assign bus.pmem_mux_sel  = reset & mux_c;
  assign bus.line_load     = reset & line_load_c;
  assign bus.tag_load      = reset & tag_load_c;
  assign bus.dirty_set     = reset & dirty_set_c;
  assign bus.lru_update    = reset & lru_update_c;
  assign bus.beat_idx      = beat_cnt;
  assign bus.miss_count    = miss_cnt;

endmodule

// File: tb/tb_cache_control_l2_assoc.sv
// Self-checking bench: a set-level cache model predicts, cycle by cycle,
// what the controller must present for each access and compares it.
module tb_cache_control_l2_assoc;
  localparam int WAYS    = 4;
  localparam int BEATS   = 4;
  localparam int CNT_W   = 2;
  localparam int WAY_W   = 2;
  localparam int BEAT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cache_control_l2_assoc_if #(.WAYS(WAYS), .BEATS(BEATS), .CNT_W(CNT_W)) bus ();

  cache_control_l2_assoc #(.WAYS(WAYS), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the single indexed set plus the miss counter.
  int tags   [WAYS];
  bit mvalid [WAYS];
  bit mdirty [WAYS];
  int lru_q  [$];
  int mcount;

  // One expected cycle; e_ctl = {resp, pmem_read, pmem_write, line_load, tag_load, dirty_set, lru_update}.
  typedef struct {
    bit             req;
    bit             wr;
    bit             hit;
    int             hit_way;
    bit             presp;
    logic [WAYS-1:0] vv;
    logic [WAYS-1:0] dv;
    int             lru;
    logic [6:0]     e_ctl;
    bit             chk_sel;
    int             e_sel;
    bit             chk_mux;
    bit             e_mux;
    int             e_beat;
    int             e_miss;
  } step_t;

  step_t plan [$];

  function automatic void reset_model();
    lru_q.delete();
    for (int i = 0; i < WAYS; i++) begin
      tags[i]   = -1;
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      lru_q.push_back(i);
    end
    mcount = 0;
  endfunction

  function automatic int lookup(input int tag);
    for (int i = 0; i < WAYS; i++) if (mvalid[i] && tags[i] == tag) return i;
    return -1;
  endfunction

  function automatic void touch(input int w);
    for (int i = 0; i < lru_q.size(); i++) begin
      if (lru_q[i] == w) begin
        lru_q.delete(i);
        break;
      end
    end
    lru_q.push_back(w);
  endfunction

  function automatic step_t base_step(input bit req, input bit wr);
    step_t s;
    s.req     = req;
    s.wr      = wr;
    s.hit     = 1'b0;
    s.hit_way = 0;
    s.presp   = 1'($urandom_range(1, 0));
    for (int i = 0; i < WAYS; i++) begin
      s.vv[i] = mvalid[i];
      s.dv[i] = mdirty[i];
    end
    s.lru     = lru_q[0];
    s.e_ctl   = '0;
    s.chk_sel = 1'b0;
    s.e_sel   = 0;
    s.chk_mux = 1'b0;
    s.e_mux   = 1'b0;
    s.e_beat  = 0;
    s.e_miss  = mcount;
    return s;
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) plan.push_back(base_step(1'b0, 1'b0));
  endfunction

  // Expands one CPU access into the cycles the controller must produce.
  function automatic void build_access(input int tag, input bit wr, input int stall_max,
                                       input int drop_after);
    step_t s;
    int    h, v, n;
    bit    wb, rq, dropped;
    h = lookup(tag);
    if (h >= 0) begin
      s = base_step(1'b1, wr);
      s.hit = 1'b1;  s.hit_way = h;
      s.e_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wr, 1'b1};
      s.chk_sel = 1'b1;  s.e_sel = h;
      plan.push_back(s);
      touch(h);
      if (wr) mdirty[h] = 1'b1;
      return;
    end
    v = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (!mvalid[i]) v = i;
    if (v < 0) v = lru_q[0];
    wb = mvalid[v] && mdirty[v];
    plan.push_back(base_step(1'b1, wr));
    mcount  = (mcount == CNT_MAX) ? mcount : mcount + 1;
    dropped = 1'b0;
    if (wb) begin
      for (int b = 0; b < BEATS; b++) begin
        rq = !(drop_after >= 0 && b > drop_after);
        if (!rq) dropped = 1'b1;
        n = int'($urandom_range(stall_max, 0));
        for (int k = 0; k <= n; k++) begin
          s = base_step(rq, wr);
          s.presp = (k == n);
          s.e_ctl = 7'b0010000;
          s.chk_sel = 1'b1;  s.e_sel = v;
          s.chk_mux = 1'b1;  s.e_mux = 1'b1;
          s.e_beat = b;
          plan.push_back(s);
        end
      end
    end
    if (dropped) begin
      add_idle(1);
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      n = int'($urandom_range(stall_max, 0));
      for (int k = 0; k <= n; k++) begin
        s = base_step(1'b1, wr);
        s.presp = (k == n);
        s.e_ctl = {1'b0, 1'b1, 1'b0, s.presp, 1'b0, 1'b0, 1'b0};
        s.chk_sel = 1'b1;  s.e_sel = v;
        s.chk_mux = 1'b1;  s.e_mux = 1'b0;
        s.e_beat = b;
        plan.push_back(s);
      end
    end
    s = base_step(1'b1, wr);
    s.e_ctl = 7'b0000100;
    s.chk_sel = 1'b1;  s.e_sel = v;
    plan.push_back(s);
    s = base_step(1'b1, wr);
    s.hit = 1'b1;  s.hit_way = v;
    s.e_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wr, 1'b1};
    s.chk_sel = 1'b1;  s.e_sel = v;
    plan.push_back(s);
    tags[v]   = tag;
    mvalid[v] = 1'b1;
    mdirty[v] = wr;
    touch(v);
  endfunction

  // Plays the queued cycles: drive at negedge, sample 1ns later.
  task automatic run_plan(input string name, output int resp_at);
    step_t      s;
    logic [6:0] ctl;
    resp_at = -1;
    for (int i = 0; i < plan.size(); i++) begin
      s = plan[i];
      @(negedge clk);
      bus.mem_write = s.req & s.wr;
      bus.mem_read  = s.req & (!s.wr | 1'($urandom_range(1, 0)));
      bus.hit       = s.hit;
      bus.hit_way   = s.hit ? WAY_W'(s.hit_way) : WAY_W'($urandom_range(WAYS - 1, 0));
      bus.valid_vec = s.vv;
      bus.dirty_vec = s.dv;
      bus.lru_way   = WAY_W'(s.lru);
      bus.pmem_resp = s.presp;
      #1;
      ctl = {bus.real_mem_resp, bus.pmem_read, bus.pmem_write, bus.line_load,
             bus.tag_load, bus.dirty_set, bus.lru_update};
      if (ctl[6] === 1'b1 && resp_at < 0) resp_at = i;
      checks++;
      if (ctl !== s.e_ctl) begin
        errors++;
        $display("[TB] FAIL %s step %0d ctl got %b want %b", name, i, ctl, s.e_ctl);
      end
      checks++;
      if (bus.beat_idx !== BEAT_W'(s.e_beat)) begin
        errors++;
        $display("[TB] FAIL %s step %0d beat_idx got %0d want %0d", name, i, bus.beat_idx, s.e_beat);
      end
      checks++;
      if (bus.miss_count !== CNT_W'(s.e_miss)) begin
        errors++;
        $display("[TB] FAIL %s step %0d miss_count got %0d want %0d", name, i, bus.miss_count, s.e_miss);
      end
      if (s.chk_sel) begin
        checks++;
        if (bus.sel_way !== WAY_W'(s.e_sel)) begin
          errors++;
          $display("[TB] FAIL %s step %0d sel_way got %0d want %0d", name, i, bus.sel_way, s.e_sel);
        end
      end
      if (s.chk_mux) begin
        checks++;
        if (bus.pmem_mux_sel !== s.e_mux) begin
          errors++;
          $display("[TB] FAIL %s step %0d pmem_mux_sel got %b want %b", name, i, bus.pmem_mux_sel, s.e_mux);
        end
      end
    end
    plan.delete();
  endtask

  function automatic logic [WAY_W+BEAT_W+CNT_W+7:0] all_outputs();
    return {bus.real_mem_resp, bus.sel_way, bus.pmem_read, bus.pmem_write, bus.pmem_mux_sel,
            bus.beat_idx, bus.line_load, bus.tag_load, bus.dirty_set, bus.lru_update,
            bus.miss_count};
  endfunction

  task automatic test_reset();
    int resp_at;
    @(negedge clk);
    bus.mem_read = 1'b1;  bus.mem_write = 1'b1;  bus.hit = 1'b1;  bus.hit_way = 2'd2;
    bus.pmem_resp = 1'b1;  bus.valid_vec = '1;  bus.dirty_vec = '1;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", all_outputs());
    end
    @(negedge clk);
    reset = 1'b1;
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.hit = 1'b0;  bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.beat_idx, bus.miss_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release got %b want 0",
               {bus.pmem_read, bus.pmem_write, bus.beat_idx, bus.miss_count});
    end
    reset_model();
    tags[1] = 5;  mvalid[1] = 1'b1;
    build_access(5, 1'b0, 0, -1);
    run_plan("reset_first_hit", resp_at);
    checks++;
    if (resp_at !== 0) begin
      errors++;
      $display("[TB] FAIL reset_first_hit latency got %0d want 0", resp_at);
    end
  endtask

  task automatic test_read_hit();
    int resp_at;
    for (int i = 0; i < WAYS; i++) begin
      tags[i] = 10 + i;  mvalid[i] = 1'b1;  mdirty[i] = 1'b0;
    end
    build_access(12, 1'b0, 0, -1);
    build_access(11, 1'b1, 0, -1);
    run_plan("read_hit", resp_at);
    checks++;
    if (resp_at !== 0) begin
      errors++;
      $display("[TB] FAIL read_hit latency got %0d want 0", resp_at);
    end
  endtask

  task automatic test_read_miss_clean();
    int resp_at;
    mvalid[2] = 1'b0;
    build_access(20, 1'b0, 0, -1);
    run_plan("read_miss_clean", resp_at);
    checks++;
    if (resp_at !== BEATS + 2) begin
      errors++;
      $display("[TB] FAIL read_miss_clean latency got %0d want %0d", resp_at, BEATS + 2);
    end
    checks++;
    if (bus.miss_count !== CNT_W'(1)) begin
      errors++;
      $display("[TB] FAIL read_miss_clean miss_count got %0d want 1", bus.miss_count);
    end
  endtask

  task automatic test_write_miss_dirty();
    int resp_at;
    for (int i = 0; i < WAYS; i++) begin
      mvalid[i] = 1'b1;  mdirty[i] = (i == 2);
    end
    lru_q = {2, 0, 1, 3};
    build_access(30, 1'b1, 0, -1);
    run_plan("write_miss_dirty", resp_at);
    checks++;
    if (resp_at !== 2 * BEATS + 2) begin
      errors++;
      $display("[TB] FAIL write_miss_dirty latency got %0d want %0d", resp_at, 2 * BEATS + 2);
    end
  endtask

  task automatic test_drop_mid_writeback();
    int resp_at;
    mdirty[lru_q[0]] = 1'b1;
    build_access(40, 1'b1, 0, 1);
    run_plan("drop_mid_wb", resp_at);
    checks++;
    if (resp_at !== -1) begin
      errors++;
      $display("[TB] FAIL drop_mid_wb resp got step %0d want none", resp_at);
    end
  endtask

  task automatic test_reset_mid_allocate();
    int resp_at;
    for (int i = 0; i < WAYS; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    bus.mem_read = 1'b1;  bus.mem_write = 1'b0;  bus.hit = 1'b0;
    bus.valid_vec = '0;  bus.dirty_vec = '0;  bus.lru_way = '0;  bus.pmem_resp = 1'b0;
    @(negedge clk);  bus.pmem_resp = 1'b1;
    @(negedge clk);  bus.pmem_resp = 1'b1;
    @(negedge clk);  bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.beat_idx} !== {1'b1, BEAT_W'(2)}) begin
      errors++;
      $display("[TB] FAIL mid_alloc in-flight got %b want %b", {bus.pmem_read, bus.beat_idx},
               {1'b1, BEAT_W'(2)});
    end
    #1;
    reset = 1'b0;
    bus.hit = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("[TB] FAIL mid_alloc reset_outputs got %h want 0", all_outputs());
    end
    @(negedge clk);
    reset = 1'b1;
    bus.mem_read = 1'b0;  bus.hit = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.beat_idx, bus.miss_count} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_alloc after_release got %b want 0",
               {bus.pmem_read, bus.pmem_write, bus.beat_idx, bus.miss_count});
    end
    mcount = 0;
    tags[3] = 77;  mvalid[3] = 1'b1;
    build_access(77, 1'b1, 0, -1);
    run_plan("mid_alloc_rehit", resp_at);
    checks++;
    if (resp_at !== 0) begin
      errors++;
      $display("[TB] FAIL mid_alloc_rehit latency got %0d want 0", resp_at);
    end
  endtask

  task automatic test_miss_saturation();
    int resp_at;
    for (int t = 0; t < 4; t++) build_access(200 + t, 1'b0, 0, -1);
    add_idle(1);
    run_plan("miss_saturation", resp_at);
    checks++;
    if (bus.miss_count !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("[TB] FAIL miss_saturation got %0d want %0d", bus.miss_count, CNT_MAX);
    end
  endtask

  task automatic test_back_to_back();
    int resp_at;
    for (int i = 0; i < WAYS; i++) begin
      tags[i] = 300 + i;  mvalid[i] = 1'b1;  mdirty[i] = 1'b0;
    end
    for (int n = 0; n < 8; n++)
      build_access(300 + int'($urandom_range(WAYS - 1, 0)), 1'($urandom_range(1, 0)), 0, -1);
    run_plan("back_to_back", resp_at);
  endtask

  task automatic test_random();
    int resp_at, t, drop;
    bit wr;
    for (int n = 0; n < 40; n++) begin
      t    = int'($urandom_range(7, 0));
      wr   = 1'($urandom_range(1, 0));
      drop = ($urandom_range(3, 0) == 0) ? int'($urandom_range(BEATS - 2, 0)) : -1;
      build_access(t, wr, 2, drop);
      if ($urandom_range(1, 0) == 1) add_idle(1);
      run_plan("random", resp_at);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.hit = 1'b0;  bus.hit_way = '0;
    bus.valid_vec = '0;  bus.dirty_vec = '0;  bus.lru_way = '0;  bus.pmem_resp = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    $display("[TB] starting");
    test_reset();
    test_read_hit();
    test_read_miss_clean();
    test_write_miss_dirty();
    test_drop_mid_writeback();
    test_reset_mid_allocate();
    test_miss_saturation();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_control_l2_assoc.md
CACHE_CONTROL_L2_ASSOC -- requirements
Module: cache_control_l2_assoc

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  WAYS  4  associativity; power of 2, 2..8.
  BEATS  4  pmem transfers per line; 1..8.
  CNT_W  16  width of miss counter.
  Derived: WAY_W = max(1, clog2(WAYS)); BEAT_W = max(1, clog2(BEATS)).
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on posedge.
  reset  in  1  asynchronous, active-low reset.
  mem_read  in  1  CPU-side read request; held until real_mem_resp.
  mem_write  in  1  CPU-side write request; held until real_mem_resp.
  hit  in  1  tag match in the indexed set.
  hit_way  in  WAY_W  matching way; valid only when hit=1.
  valid_vec  in  WAYS  valid bits of the indexed set.
  dirty_vec  in  WAYS  dirty bits of the indexed set.
  lru_way  in  WAY_W  LRU way of the indexed set.
  pmem_resp  in  1  per-beat acknowledge from physical memory.
  real_mem_resp  out  1  CPU request complete.
  sel_way  out  WAY_W  way steered to the datapath.
  pmem_read  out  1  burst read active.
  pmem_write  out  1  burst write active.
  pmem_mux_sel  out  1  1 = pmem address from victim tag; 0 = from CPU tag.
  beat_idx  out  BEAT_W  current beat within the line.
  line_load  out  1  write the current fill beat into sel_way.
  tag_load  out  1  load tag, set valid, clear dirty for sel_way.
  dirty_set  out  1  set dirty for sel_way (write hit).
  lru_update  out  1  mark sel_way most-recently-used.
  miss_count  out  CNT_W  saturating miss counter.

Function
REQ-003 States: CHECK, WRITE_BACK, ALLOCATE, UPDATE.
REQ-004 req = mem_read | mem_write; both high is treated as a write.
REQ-005 CHECK with req & hit: real_mem_resp=1, sel_way=hit_way, lru_update=1, and dirty_set=mem_write, all combinationally in the same cycle; the FSM stays in CHECK.
REQ-006 CHECK with req & !hit: latch victim = lowest-index way with valid_vec=0, else lru_way; miss_count increments, saturating at all-ones.
REQ-007 In the same miss cycle: next state is WRITE_BACK if valid_vec[victim] & dirty_vec[victim], else ALLOCATE; beat counter clears to 0.
REQ-008 WRITE_BACK: pmem_write=1, pmem_mux_sel=1, sel_way=victim.
REQ-009 ALLOCATE: pmem_read=1, pmem_mux_sel=0, sel_way=victim, line_load=pmem_resp.
REQ-010 Beat counter increments on each pmem_resp during a burst; beat_idx = counter.
REQ-011 A burst ends on the pmem_resp with beat_idx=BEATS-1; the counter then returns to 0 and pmem_read/pmem_write deassert the next cycle.
REQ-012 A started burst always completes; a request dropped mid-burst never aborts it.
REQ-013 End of WRITE_BACK: go to ALLOCATE if req is still high, else CHECK.
REQ-014 End of ALLOCATE: go to UPDATE unconditionally.
REQ-015 UPDATE, exactly one cycle: tag_load=1, sel_way=victim, then CHECK; the retried access hits in the following CHECK cycle.
REQ-016 real_mem_resp is never asserted outside CHECK.
REQ-017 pmem_read and pmem_write are never both high.
REQ-018 pmem_resp outside WRITE_BACK/ALLOCATE is ignored.
REQ-019 BEATS=1: every burst ends on its first pmem_resp; beat_idx stays 0.
REQ-020 Miss latency with no pmem stalls: clean victim = BEATS+2 cycles to real_mem_resp; dirty victim = 2*BEATS+2.

Reset
REQ-021 reset low asynchronously forces state=CHECK, beat counter=0, victim=0, miss_count=0.
REQ-022 While reset is low, all outputs are 0; an in-flight burst is abandoned.
REQ-023 Normal operation resumes on the first posedge clk after reset deasserts.

Verification
REQ-024 WAYS=4, BEATS=4, read with hit=1, hit_way=2 -> same-cycle real_mem_resp=1, sel_way=2, lru_update=1, dirty_set=0; miss_count=0.
REQ-025 Read miss, valid_vec=4'b1011 -> victim=2; ALLOCATE, 4 beats with line_load on each pmem_resp, beat_idx 0..3; UPDATE tag_load=1; hit -> resp; miss_count=1.
REQ-026 Write miss, valid_vec=4'b1111, dirty_vec=4'b0100, lru_way=2 -> WRITE_BACK (pmem_write=1, pmem_mux_sel=1) 4 beats, then ALLOCATE 4 beats, UPDATE, CHECK; total latency 10 cycles with single-cycle pmem_resp.
REQ-027 Request dropped after beat 1 of WRITE_BACK -> burst completes 4 beats, FSM returns to CHECK, no ALLOCATE, no real_mem_resp.
REQ-028 Reset pulsed low mid-ALLOCATE (beat 2) -> outputs 0 immediately; after release state=CHECK, beat_idx=0, miss_count=0.
REQ-029 CNT_W=2, four misses -> miss_count saturates at 3.
